// File: rtl/mem_ctrl_pkg.sv
// Shared types and encodings for the memory access controller: FSM states,
// IorD mux select encodings and grant bit positions.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] IORD_PC  = 2'b00;
  localparam logic [1:0] IORD_EXC = 2'b01;
  localparam logic [1:0] IORD_ALU = 2'b10;
  localparam logic [1:0] IORD_RES = 2'b11;

  localparam int GNT_FETCH = 0;
  localparam int GNT_EXC   = 1;
  localparam int GNT_LS    = 2;
  localparam int GNT_RES   = 3;

  localparam int CNT_W = 3;

  // An empty grant (idle) selects the PC, same as a fetch.
  function automatic logic [1:0] iord_of(input logic [3:0] gnt);
    logic [1:0] sel;
    sel = IORD_PC;
    if (gnt[GNT_EXC]) sel = IORD_EXC;
    if (gnt[GNT_LS])  sel = IORD_ALU;
    if (gnt[GNT_RES]) sel = IORD_RES;
    return sel;
  endfunction

endpackage

// File: rtl/mem_req_arb.sv
// Combinational fixed-priority arbiter: exc > ls > res > fetch, one-hot grant.
module mem_req_arb
  import mem_ctrl_pkg::*;
(
  input  logic [3:0] req,
  output logic [3:0] gnt
);

  // NOTE: gnt gets a default before the priority chain so no path leaves it
  // unassigned; without it synthesis infers a latch.
  always_comb begin
    gnt = '0;
    if (req[GNT_EXC])        gnt[GNT_EXC]   = 1'b1;
    else if (req[GNT_LS])    gnt[GNT_LS]    = 1'b1;
    else if (req[GNT_RES])   gnt[GNT_RES]   = 1'b1;
    else if (req[GNT_FETCH]) gnt[GNT_FETCH] = 1'b1;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle memory access sequencer (IDLE/ADDR/WAIT/DONE) for fetch,
// exception-vector, load/store and result accesses. Optional alignment
// fault detection on word load/store under MEM_ACCESS_CTRL_ALIGN_CHECK_EN.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       fetch_req,
  input  logic       exc_req,
  input  logic       ls_req,
  input  logic       ls_we,
  input  logic       res_req,
  input  logic       res_we,
  input  logic [1:0] ls_addr_lsb,
  input  logic       ls_word,
  output logic [1:0] iord_sel,
  output logic       mem_wr,
  output logic [3:0] grant,
  output logic       busy,
  output logic       done,
  output logic       misalign
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q;
  logic [3:0]       req_vec;
  logic [3:0]       arb_gnt;
  logic [3:0]       grant_q;
  logic             we_q;
  logic             we_d;
  logic             mis_d;
  logic             mis_q;
  logic [CNT_W-1:0] cnt_q;

  // Bit order follows GNT_RES/GNT_LS/GNT_EXC/GNT_FETCH = 3/2/1/0.
  assign req_vec = {res_req, ls_req, exc_req, fetch_req};

  mem_req_arb u_arb (
    .req (req_vec),
    .gnt (arb_gnt)
  );

`ifdef MEM_ACCESS_CTRL_ALIGN_CHECK_EN
  assign mis_d = arb_gnt[GNT_LS] & ls_word & (ls_addr_lsb != 2'b00);
`else
  logic unused_align;
  assign unused_align = ^{ls_word, ls_addr_lsb};
  assign mis_d        = 1'b0;
`endif

  // The write qualifier is captured once at grant; later changes are ignored.
  assign we_d = ((arb_gnt[GNT_LS] & ls_we) | (arb_gnt[GNT_RES] & res_we)) & ~mis_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|arb_gnt) begin
            grant_q <= arb_gnt;
            we_q    <= we_d;
            mis_q   <= mis_d;
            state_q <= mis_d ? ST_DONE : ST_ADDR;
          end
        end
        ST_ADDR: begin
          cnt_q   <= CNT_LOAD;
          state_q <= (MEM_LAT == 1) ? ST_DONE : ST_WAIT;
        end
        ST_WAIT: begin
          // Counter saturates at zero; reaching 1 ends the wait.
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q <= CNT_ONE) state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          we_q    <= 1'b0;
          mis_q   <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant    = grant_q;
  assign iord_sel = iord_of(grant_q);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign mem_wr   = (state_q == ST_ADDR) & we_q;
  // mis_q never sets when alignment checking is compiled out.
  assign misalign = mis_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: three controllers (MEM_LAT 1, 2, 7) share one stimulus
// stream and are compared every cycle against a transaction-level model.
module tb_mem_access_ctrl;

  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       fetch_req = 1'b0, exc_req = 1'b0, ls_req = 1'b0, res_req = 1'b0;
  logic       ls_we = 1'b0, res_we = 1'b0, ls_word = 1'b0;
  logic [1:0] ls_addr_lsb = 2'b00;

  logic [1:0] iord_w   [NDUT];
  logic       mem_wr_w [NDUT];
  logic [3:0] grant_w  [NDUT];
  logic       busy_w   [NDUT];
  logic       done_w   [NDUT];
  logic       mis_w    [NDUT];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mem_access_ctrl #(.MEM_LAT((g == 0) ? 1 : (g == 1) ? 2 : 7)) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .fetch_req   (fetch_req),
      .exc_req     (exc_req),
      .ls_req      (ls_req),
      .ls_we       (ls_we),
      .res_req     (res_req),
      .res_we      (res_we),
      .ls_addr_lsb (ls_addr_lsb),
      .ls_word     (ls_word),
      .iord_sel    (iord_w[g]),
      .mem_wr      (mem_wr_w[g]),
      .grant       (grant_w[g]),
      .busy        (busy_w[g]),
      .done        (done_w[g]),
      .misalign    (mis_w[g])
    );
  end

  task automatic check(input string name, input int d, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : 7;
  endfunction

  // Model: an access is a run of cycles numbered 1..last after the granting
  // edge; position 1 carries the write strobe, the last position is done.
  bit         m_act [NDUT];
  int         m_pos [NDUT];
  logic [3:0] m_gnt [NDUT];
  bit         m_we  [NDUT];
  bit         m_mis [NDUT];

  function automatic int m_last(input int d);
    return m_mis[d] ? 1 : lat_of(d) + 1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    for (int d = 0; d < NDUT; d++) begin
      if (!reset_n) begin
        m_act[d] = 1'b0;
      end else if (m_act[d]) begin
        if (m_pos[d] == m_last(d)) m_act[d] = 1'b0;
        else m_pos[d] = m_pos[d] + 1;
      end else if (exc_req | ls_req | res_req | fetch_req) begin
        m_act[d] = 1'b1;
        m_pos[d] = 1;
        m_mis[d] = 1'b0;
        if (exc_req)      begin m_gnt[d] = 4'b0010; m_we[d] = 1'b0;   end
        else if (ls_req)  begin m_gnt[d] = 4'b0100; m_we[d] = ls_we;  end
        else if (res_req) begin m_gnt[d] = 4'b1000; m_we[d] = res_we; end
        else              begin m_gnt[d] = 4'b0001; m_we[d] = 1'b0;   end
`ifdef MEM_ACCESS_CTRL_ALIGN_CHECK_EN
        if (m_gnt[d] == 4'b0100 && ls_word && ls_addr_lsb != 2'b00) m_mis[d] = 1'b1;
`endif
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] e_gnt;
    logic [1:0] e_iord;
    logic       e_busy, e_wr, e_done, e_mis;
    for (int d = 0; d < NDUT; d++) begin
      e_gnt = 4'b0000; e_iord = 2'b00; e_busy = 1'b0; e_wr = 1'b0; e_done = 1'b0; e_mis = 1'b0;
      if (m_act[d]) begin
        e_gnt  = m_gnt[d];
        e_busy = 1'b1;
        case (m_gnt[d])
          4'b0010: e_iord = 2'b01;
          4'b0100: e_iord = 2'b10;
          4'b1000: e_iord = 2'b11;
          default: e_iord = 2'b00;
        endcase
        e_wr   = (m_pos[d] == 1) && m_we[d] && !m_mis[d];
        e_done = (m_pos[d] == m_last(d));
        e_mis  = m_mis[d] && e_done;
      end
      check("grant",    d, 8'(grant_w[d]),  8'(e_gnt));
      check("iord_sel", d, 8'(iord_w[d]),   8'(e_iord));
      check("busy",     d, 8'(busy_w[d]),   8'(e_busy));
      check("mem_wr",   d, 8'(mem_wr_w[d]), 8'(e_wr));
      check("done",     d, 8'(done_w[d]),   8'(e_done));
      check("misalign", d, 8'(mis_w[d]),    8'(e_mis));
    end
  end

  task automatic wait_idle();
    fetch_req = 1'b0; exc_req = 1'b0; ls_req = 1'b0; res_req = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  logic [5:0] seq_g [4];
  int         seq_n;
  int         wr_cnt;

  // Tracks the MEM_LAT=2 controller, dropping each request at its done.
  task automatic run_seq(input int exc_at);
    logic prev;
    prev = 1'b0; seq_n = 0; wr_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == exc_at) exc_req = 1'b1;
      if (busy_w[1] && !prev && seq_n < 4) begin
        seq_g[seq_n] = {iord_w[1], grant_w[1]};
        seq_n++;
      end
      if (mem_wr_w[1]) wr_cnt++;
      if (done_w[1]) begin
        case (grant_w[1])
          4'b0001: fetch_req = 1'b0;
          4'b0010: exc_req   = 1'b0;
          4'b0100: ls_req    = 1'b0;
          4'b1000: res_req   = 1'b0;
          default: ;
        endcase
      end
      prev = busy_w[1];
      if (k > exc_at && !(fetch_req | exc_req | ls_req | res_req)) break;
    end
    check("seq_drained", 1, 8'(fetch_req | exc_req | ls_req | res_req), 8'd0);
  endtask

  int dc [NDUT];

  initial begin
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // Fetch held from cycle 0 on MEM_LAT=2: ADDR/WAIT/DONE in cycles 1-3.
    @(posedge clk); #2 fetch_req = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check("lit_fetch_grant", 1, 8'(grant_w[1]),  (k >= 1 && k <= 3) ? 8'h01 : 8'h00);
      check("lit_fetch_iord",  1, 8'(iord_w[1]),   8'h00);
      check("lit_fetch_wr",    1, 8'(mem_wr_w[1]), 8'h00);
      check("lit_fetch_done",  1, 8'(done_w[1]),   (k == 3) ? 8'h01 : 8'h00);
    end
    wait_idle();

    // Single result access: done cycle per latency.
    res_req = 1'b1;
    for (int d = 0; d < NDUT; d++) dc[d] = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) if (done_w[d] && dc[d] < 0) dc[d] = k;
    end
    check("lit_done_cyc_lat1", 0, 8'(dc[0]), 8'd2);
    check("lit_done_cyc_lat2", 1, 8'(dc[1]), 8'd3);
    check("lit_done_cyc_lat7", 2, 8'(dc[2]), 8'd8);
    wait_idle();

    // Simultaneous fetch, store and exception: served exc, ls, fetch.
    fetch_req = 1'b1; ls_req = 1'b1; ls_we = 1'b1; exc_req = 1'b1;
    run_seq(0);
    check("lit_order_n",  1, 8'(seq_n),    8'd3);
    check("lit_order_0",  1, 8'(seq_g[0]), 8'h12);
    check("lit_order_1",  1, 8'(seq_g[1]), 8'h24);
    check("lit_order_2",  1, 8'(seq_g[2]), 8'h01);
    check("lit_order_wr", 1, 8'(wr_cnt),   8'd1);
    ls_we = 1'b0;
    wait_idle();

    // Exception raised during a fetch's WAIT waits for the fetch to finish.
    fetch_req = 1'b1;
    run_seq(2);
    check("lit_nopre_n", 1, 8'(seq_n),    8'd2);
    check("lit_nopre_0", 1, 8'(seq_g[0]), 8'h01);
    check("lit_nopre_1", 1, 8'(seq_g[1]), 8'h12);
    wait_idle();

    // Reset during WAIT clears outputs at once; held fetch re-arbitrated.
    fetch_req = 1'b1;
    @(negedge clk); @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check("lit_rst_busy",  d, 8'(busy_w[d]),   8'h00);
      check("lit_rst_grant", d, 8'(grant_w[d]),  8'h00);
      check("lit_rst_iord",  d, 8'(iord_w[d]),   8'h00);
      check("lit_rst_wr",    d, 8'(mem_wr_w[d]), 8'h00);
      check("lit_rst_done",  d, 8'(done_w[d]),   8'h00);
      check("lit_rst_mis",   d, 8'(mis_w[d]),    8'h00);
    end
    @(negedge clk); #1 reset_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("lit_rearb_grant", 1, 8'(grant_w[1]), 8'h01);
      check("lit_rearb_done",  1, 8'(done_w[1]),  (k == 3) ? 8'h01 : 8'h00);
    end
    wait_idle();

    // Misaligned word store.
    ls_req = 1'b1; ls_we = 1'b1; ls_word = 1'b1; ls_addr_lsb = 2'b10;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
`ifdef MEM_ACCESS_CTRL_ALIGN_CHECK_EN
      check("lit_mis_done", 1, 8'(done_w[1]),   (k == 1) ? 8'h01 : 8'h00);
      check("lit_mis_flag", 1, 8'(mis_w[1]),    (k == 1) ? 8'h01 : 8'h00);
      check("lit_mis_wr",   1, 8'(mem_wr_w[1]), 8'h00);
      if (k == 1) ls_req = 1'b0;
`else
      check("lit_mis_done", 1, 8'(done_w[1]),   (k == 3) ? 8'h01 : 8'h00);
      check("lit_mis_flag", 1, 8'(mis_w[1]),    8'h00);
      check("lit_mis_wr",   1, 8'(mem_wr_w[1]), (k == 1) ? 8'h01 : 8'h00);
      if (k == 3) ls_req = 1'b0;
`endif
    end
    ls_we = 1'b0; ls_word = 1'b0; ls_addr_lsb = 2'b00;
    wait_idle();

    // Random traffic with occasional reset pulses; the model checks it all.
    @(posedge clk);
    for (int c = 0; c < 3000; c++) begin
      #2;
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(0, 399) == 0) reset_n = 1'b0;
      if ($urandom_range(0, 5) == 0) fetch_req = ~fetch_req;
      if ($urandom_range(0, 9) == 0) exc_req   = ~exc_req;
      if ($urandom_range(0, 5) == 0) ls_req    = ~ls_req;
      if ($urandom_range(0, 5) == 0) res_req   = ~res_req;
      ls_we       = 1'($urandom_range(0, 1));
      res_we      = 1'($urandom_range(0, 1));
      ls_word     = 1'($urandom_range(0, 1));
      ls_addr_lsb = 2'($urandom_range(0, 3));
      @(posedge clk);
    end
    #2 reset_n = 1'b1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
